// File: rtl/axi_rr_arb_multiplexer.sv
// axi_rr_arb_multiplexer
//   Registered N_IN:1 multiplexer with internal round-robin arbitration and a
//   valid/ready handshake on both sides. With LOCK_EN=1 the grant is held from
//   the first beat of a burst until a beat with LAST is accepted, so beats of
//   different initiators never interleave on the output.
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   IN_DATA      packed per-input payloads
//   IN_VALID     per-input valid
//   IN_LAST      per-input last-beat flag
//   IN_READY     per-input ready, one-hot or zero
//   OUT_DATA     registered payload
//   OUT_LAST     registered last flag
//   OUT_SEL      index of the input that produced the current output beat
//   OUT_VALID    output valid
//   OUT_READY    downstream ready
module axi_rr_arb_multiplexer #(
  parameter int DATA_WIDTH = 64,
  parameter int N_IN       = 16,
  parameter int SEL_WIDTH  = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int LOCK_EN    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_IN-1:0][DATA_WIDTH-1:0]    IN_DATA,
  input  logic [N_IN-1:0]                    IN_VALID,
  input  logic [N_IN-1:0]                    IN_LAST,
  output logic [N_IN-1:0]                    IN_READY,
  output logic [DATA_WIDTH-1:0]              OUT_DATA,
  output logic                               OUT_LAST,
  output logic [SEL_WIDTH-1:0]               OUT_SEL,
  output logic                               OUT_VALID,
  input  logic                               OUT_READY
);

  localparam int unsigned N = N_IN;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state, next_state;
  logic [SEL_WIDTH-1:0]   rr_ptr, rr_next;
  logic [SEL_WIDTH-1:0]   lock_idx, next_lock;
  logic [SEL_WIDTH-1:0]   rr_idx, grant_idx;
  logic                   grant_vld, accept, xfer_in;
  logic                   sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;

  // First valid input at or after rr_ptr, wrapping N_IN-1 -> 0.
  always_comb begin : rr_search
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = k + 32'(rr_ptr);
      if (idx >= N) idx = idx - N;
      if (!found && IN_VALID[idx]) begin
        found  = 1'b1;
        rr_idx = SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    if (state == LOCKED) begin
      grant_idx = lock_idx;
      grant_vld = 1'b1;
    end else begin
      grant_idx = rr_idx;
      grant_vld = |IN_VALID;
    end
  end

  assign accept = ~OUT_VALID | OUT_READY;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    IN_READY  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        sel_valid   = IN_VALID[i];
        sel_last    = IN_LAST[i];
        sel_data    = IN_DATA[i];
        IN_READY[i] = accept & grant_vld;
      end
    end
  end

  // While LOCKED the grant is forced, so the granted input's own valid
  // decides whether a beat actually moves.
  assign xfer_in = accept & grant_vld & sel_valid;

  assign rr_next = (grant_idx == SEL_WIDTH'(N_IN - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    next_state = state;
    next_lock  = lock_idx;
    if (xfer_in) begin
      case (state)
        IDLE: begin
          if ((LOCK_EN != 0) && !sel_last) begin
            next_state = LOCKED;
            next_lock  = grant_idx;
          end
        end
        LOCKED: begin
          if (sel_last) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= next_state;
      lock_idx <= next_lock;
      if (xfer_in && (sel_last || (LOCK_EN == 0))) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LAST  <= 1'b0;
      OUT_SEL   <= '0;
    end else if (xfer_in) begin
      OUT_VALID <= 1'b1;
      OUT_DATA  <= sel_data;
      OUT_LAST  <= sel_last;
      OUT_SEL   <= grant_idx;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rr_arb_multiplexer.sv
// Testbench for axi_rr_arb_multiplexer: three instances (16 inputs locked,
// 4 inputs unlocked, 5 inputs locked) driven by directed vectors.
module tb_axi_rr_arb_multiplexer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-input, LOCK_EN=1, 64-bit
  logic [15:0][63:0] d16;
  logic [15:0]       v16, l16, rdy16;
  logic [63:0]       od16;
  logic              ol16, ov16, r16;
  logic [3:0]        os16;

  // 4-input, LOCK_EN=0, 8-bit
  logic [3:0][7:0]   d4;
  logic [3:0]        v4, l4, rdy4;
  logic [7:0]        od4;
  logic              ol4, ov4, r4;
  logic [1:0]        os4;

  // 5-input, LOCK_EN=1, 8-bit
  logic [4:0][7:0]   d5;
  logic [4:0]        v5, l5, rdy5;
  logic [7:0]        od5;
  logic              ol5, ov5, r5;
  logic [2:0]        os5;

  axi_rr_arb_multiplexer #(.DATA_WIDTH(64), .N_IN(16), .LOCK_EN(1)) u16 (
    .clk(clk), .rst_n(rst_n), .IN_DATA(d16), .IN_VALID(v16), .IN_LAST(l16),
    .IN_READY(rdy16), .OUT_DATA(od16), .OUT_LAST(ol16), .OUT_SEL(os16),
    .OUT_VALID(ov16), .OUT_READY(r16));

  axi_rr_arb_multiplexer #(.DATA_WIDTH(8), .N_IN(4), .LOCK_EN(0)) u4 (
    .clk(clk), .rst_n(rst_n), .IN_DATA(d4), .IN_VALID(v4), .IN_LAST(l4),
    .IN_READY(rdy4), .OUT_DATA(od4), .OUT_LAST(ol4), .OUT_SEL(os4),
    .OUT_VALID(ov4), .OUT_READY(r4));

  axi_rr_arb_multiplexer #(.DATA_WIDTH(8), .N_IN(5), .LOCK_EN(1)) u5 (
    .clk(clk), .rst_n(rst_n), .IN_DATA(d5), .IN_VALID(v5), .IN_LAST(l5),
    .IN_READY(rdy5), .OUT_DATA(od5), .OUT_LAST(ol5), .OUT_SEL(os5),
    .OUT_VALID(ov5), .OUT_READY(r5));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input int dut, input int sel);
    case (dut)
      16:      return 64'hD000_0000_0000_0000 + 64'(sel);
      4:       return 64'(8'hA0 + sel);
      default: return 64'(8'h50 + sel);
    endcase
  endfunction

  // One cycle: drive at negedge, check IN_READY before the edge, check the
  // registered outputs just after it.
  task automatic cyc(input int dut, input string tag,
                     input logic [15:0] v, input logic [15:0] l, input logic o,
                     input logic [15:0] er, input logic eov, input int esel,
                     input logic elast);
    logic [15:0] rdy;
    logic [63:0] od;
    logic [3:0]  os;
    logic        ov, ol;
    @(negedge clk);
    case (dut)
      16:      begin v16 = v;      l16 = l;      r16 = o; end
      4:       begin v4  = v[3:0]; l4  = l[3:0]; r4  = o; end
      default: begin v5  = v[4:0]; l5  = l[4:0]; r5  = o; end
    endcase
    #1;
    case (dut)
      16:      rdy = rdy16;
      4:       rdy = {12'b0, rdy4};
      default: rdy = {11'b0, rdy5};
    endcase
    chk({tag, "_ready"}, 64'(rdy), 64'(er));
    @(posedge clk);
    #1;
    case (dut)
      16:      begin od = od16;      os = os16;         ov = ov16; ol = ol16; end
      4:       begin od = 64'(od4);  os = {2'b0, os4};  ov = ov4;  ol = ol4;  end
      default: begin od = 64'(od5);  os = {1'b0, os5};  ov = ov5;  ol = ol5;  end
    endcase
    chk({tag, "_valid"}, 64'(ov), 64'(eov));
    chk({tag, "_sel"},   64'(os), 64'(esel));
    chk({tag, "_last"},  64'(ol), 64'(elast));
    chk({tag, "_data"},  od, data_of(dut, esel));
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       o;
    logic [3:0] er;
    logic       eov;
    int         esel;
    logic       elast;
  } vec_t;

  vec_t tbl[13];

  initial begin
    for (int i = 0; i < 16; i++) d16[i] = data_of(16, i);
    for (int i = 0; i < 4; i++)  d4[i]  = data_of(4, i)[7:0];
    for (int i = 0; i < 5; i++)  d5[i]  = data_of(5, i)[7:0];
    v4 = '0; l4 = '0; r4 = 1'b1;
    v5 = '0; l5 = '0; r5 = 1'b1;

    // Unlocked 4-input: round robin, sparse requests, backpressure.
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1, 1'b1};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2, 1'b1};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 3, 1'b1};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1};
    tbl[5]  = '{4'h9, 4'hF, 1'b1, 4'h8, 1'b1, 3, 1'b1};
    tbl[6]  = '{4'h9, 4'hF, 1'b1, 4'h1, 1'b1, 0, 1'b1};
    tbl[7]  = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 0, 1'b1};
    tbl[8]  = '{4'h4, 4'hF, 1'b0, 4'h4, 1'b1, 2, 1'b1};
    tbl[9]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b1, 2, 1'b1};
    tbl[10] = '{4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1, 1'b0};
    tbl[11] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1, 1'b0};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1, 1'b0};

    // Reset with every input of u16 valid.
    v16 = 16'hFFFF; l16 = 16'hFFFF; r16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(ov16), 64'd0);
    chk("rst_sel",   64'(os16), 64'd0);
    chk("rst_data",  od16, 64'd0);
    chk("rst_last",  64'(ol16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_ready", 64'(rdy16), 64'h0001);
    @(posedge clk);
    #1;
    chk("first_valid", 64'(ov16), 64'd1);
    chk("first_sel",   64'(os16), 64'd0);
    chk("first_data",  od16, data_of(16, 0));

    // Backpressure: slot held for 5 cycles, next beat moves as soon as ready.
    for (int k = 0; k < 5; k++)
      cyc(16, "bp_hold", 16'h0004, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 0, 1'b1);
    cyc(16, "bp_release", 16'h0004, 16'hFFFF, 1'b1, 16'h0004, 1'b1, 2, 1'b1);
    cyc(16, "bp_drain",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 2, 1'b1);

    // Burst lock: in0 3 beats (with a stall) while in1 is valid throughout.
    cyc(16, "lock_b0",    16'h0003, 16'h0000, 1'b1, 16'h0001, 1'b1, 0, 1'b0);
    cyc(16, "lock_b1",    16'h0003, 16'h0000, 1'b1, 16'h0001, 1'b1, 0, 1'b0);
    cyc(16, "lock_stall", 16'h0002, 16'h0000, 1'b1, 16'h0001, 1'b0, 0, 1'b0);
    cyc(16, "lock_b2",    16'h0003, 16'h0001, 1'b1, 16'h0001, 1'b1, 0, 1'b1);
    cyc(16, "lock_next",  16'h0002, 16'h0002, 1'b1, 16'h0002, 1'b1, 1, 1'b1);
    cyc(16, "lock_idle",  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1, 1'b1);

    foreach (tbl[i])
      cyc(4, $sformatf("tbl%0d", i), 16'(tbl[i].v), 16'(tbl[i].l), tbl[i].o,
          16'(tbl[i].er), tbl[i].eov, tbl[i].esel, tbl[i].elast);

    // 5-input wrap: move rr_ptr to 4, then in4 and in0 compete.
    cyc(5, "wrap_set", 16'h0008, 16'h001F, 1'b1, 16'h0008, 1'b1, 3, 1'b1);
    cyc(5, "wrap_g4",  16'h0011, 16'h001F, 1'b1, 16'h0010, 1'b1, 4, 1'b1);
    cyc(5, "wrap_g0",  16'h0011, 16'h001F, 1'b1, 16'h0001, 1'b1, 0, 1'b1);
    cyc(5, "wrap_ptr", 16'h001F, 16'h001F, 1'b1, 16'h0002, 1'b1, 1, 1'b1);
    cyc(5, "wrap_end", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1, 1'b1);

    // Mid-burst reset while locked on in2 (u16 rr_ptr is 2 here).
    cyc(16, "mrst_lock", 16'h0004, 16'h0000, 1'b1, 16'h0004, 1'b1, 2, 1'b0);
    @(negedge clk);
    v16 = 16'h0006; l16 = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(ov16), 64'd0);
    chk("mrst_sel",   64'(os16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_ready", 64'(rdy16), 64'h0002);
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 64'(ov16), 64'd1);
    chk("mrst_out_sel",   64'(os16), 64'd1);
    chk("mrst_out_data",  od16, data_of(16, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
